// File: rtl/icache_line_fill.sv
// Instruction-cache line refill engine.
// On a miss it requests the aligned line from a word-wide memory port, collects
// WORDS_PER_LINE beats into words_o and pulses update_o so the cache writes the
// line. busy_o stalls the fetch PC whenever a fill is in flight.
module icache_line_fill #(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            miss_req_i,
  input  logic [ADDR_W-1:0]               miss_addr_i,
  input  logic                            flush_i,
  output logic                            mem_req_o,
  output logic [ADDR_W-1:0]               mem_addr_o,
  input  logic                            mem_gnt_i,
  input  logic                            mem_rvalid_i,
  input  logic [31:0]                     mem_rdata_i,
  output logic [WORDS_PER_LINE-1:0][31:0] words_o,
  output logic [ADDR_W-1:0]               fill_addr_o,
  output logic                            update_o,
  output logic                            busy_o
);

  localparam int OFS_W = $clog2(WORDS_PER_LINE) + 2;
  localparam int CNT_W = $clog2(WORDS_PER_LINE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RECV  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [ADDR_W-1:0]                 addr_q, addr_d;
  logic [WORDS_PER_LINE-1:0][31:0]   words_q, words_d;
  logic                              mem_req_q, update_q, busy_q;
  logic [ADDR_W-1:0]                 line_addr_s;

  // Line-aligned version of the missing PC.
  assign line_addr_s = {miss_addr_i[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};

  // Next-state, beat counter, address latch and word assembly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    words_d = words_q;
    case (state_q)
      S_IDLE: begin
        // flush and stray read beats are ignored while idle
        if (miss_req_i) begin
          addr_d  = line_addr_s;
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          // once granted the beats are owed, so a simultaneous flush must drain them
          cnt_d   = '0;
          state_d = flush_i ? S_DRAIN : S_RECV;
        end else if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_REQ;
        end
      end
      S_RECV: begin
        if (mem_rvalid_i) begin
          cnt_d = cnt_q + ONE_CNT;
          if (!flush_i) begin
            words_d[cnt_q] = mem_rdata_i;
          end else begin
            words_d = words_q;
          end
          // a flush on the final beat leaves nothing to drain
          if (cnt_q == LAST_CNT) begin
            state_d = flush_i ? S_IDLE : S_DONE;
          end else begin
            state_d = flush_i ? S_DRAIN : S_RECV;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_RECV;
        end
      end
      S_DONE: begin
        // the line is complete, so a flush here does not cancel the update
        state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (mem_rvalid_i) begin
          cnt_d = cnt_q + ONE_CNT;
          if (cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; outputs are registered decodes of the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      words_q   <= '0;
      mem_req_q <= 1'b0;
      update_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      words_q   <= words_d;
      mem_req_q <= (state_d == S_REQ);
      update_q  <= (state_d == S_DONE);
      busy_q    <= (state_d != S_IDLE);
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_addr_o  = addr_q;
  assign fill_addr_o = addr_q;
  assign words_o     = words_q;
  assign update_o    = update_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_icache_line_fill.sv
// Self-checking bench for icache_line_fill: scenario tasks with an update
// scoreboard (expected line words queued as beats are driven, popped on update).
module tb_icache_line_fill;

  localparam int WPL = 8;
  localparam int AW  = 32;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 miss_req;
  logic [AW-1:0]        miss_addr;
  logic                 flush;
  logic                 mem_req;
  logic [AW-1:0]        mem_addr;
  logic                 mem_gnt;
  logic                 mem_rvalid;
  logic [31:0]          mem_rdata;
  logic [WPL-1:0][31:0] words;
  logic [AW-1:0]        fill_addr;
  logic                 update;
  logic                 busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          upd_seen = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_words [WPL];

  icache_line_fill #(.WORDS_PER_LINE(WPL), .ADDR_W(AW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .miss_req_i   (miss_req),
    .miss_addr_i  (miss_addr),
    .flush_i      (flush),
    .mem_req_o    (mem_req),
    .mem_addr_o   (mem_addr),
    .mem_gnt_i    (mem_gnt),
    .mem_rvalid_i (mem_rvalid),
    .mem_rdata_i  (mem_rdata),
    .words_o      (words),
    .fill_addr_o  (fill_addr),
    .update_o     (update),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Count every cycle in which update is high.
  always @(negedge clk) begin
    if (update === 1'b1) upd_seen <= upd_seen + 1;
  end

  // Global time limit so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one read beat for one cycle; optionally record it in the model and scoreboard.
  task automatic send_beat(input logic [31:0] d, input int idx, input bit store, input bit push);
    mem_rvalid = 1'b1;
    mem_rdata  = d;
    if (store) model_words[idx] = d;
    if (push) exp_q.push_back(d);
    tick();
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; miss_req = 1'b0; miss_addr = 32'h0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < WPL; i++) model_words[i] = 32'h0;
    tick(); tick();
    n_checks++;
    if ({mem_req, update, busy} !== 3'b000) $display("FAIL reset_ctrl: got req/upd/busy=%b want 000", {mem_req, update, busy});
    else n_pass++;
    n_checks++;
    if (words !== '0) $display("FAIL reset_words: got %h want 0", words);
    else n_pass++;
    n_checks++;
    if (fill_addr !== 32'h0 || mem_addr !== 32'h0) $display("FAIL reset_addr: got fill=%h mem=%h want 0", fill_addr, mem_addr);
    else n_pass++;
    rst_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || upd_seen !== 0) $display("FAIL reset_release: got busy=%b upd=%0d want 0/0", busy, upd_seen);
    else n_pass++;
  endtask

  task automatic test_basic();
    int bad;
    logic [31:0] e;
    bad = 0;
    miss_req = 1'b1; miss_addr = 32'h0000_1234;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL basic_busy_c0: got %b want 0", busy); else n_pass++;
    tick();                                   // c1
    miss_req = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || busy !== 1'b1) $display("FAIL basic_c1: got req=%b busy=%b want 1/1", mem_req, busy); else n_pass++;
    n_checks++;
    if (mem_addr !== 32'h0000_1220) $display("FAIL basic_mem_addr: got %h want 00001220", mem_addr); else n_pass++;
    mem_gnt = 1'b1;
    tick();                                   // c2
    mem_gnt = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0) $display("FAIL basic_req_drop: got %b want 0", mem_req); else n_pass++;
    for (int i = 0; i < WPL; i++) begin       // c2..c9
      if (update !== 1'b0 || busy !== 1'b1) bad++;
      send_beat(32'hA0 + 32'(i), i, 1'b1, 1'b1);
    end
    n_checks++;
    if (bad != 0) $display("FAIL basic_recv_flags: got %0d bad cycles want 0", bad); else n_pass++;
    n_checks++;                               // c10
    if (update !== 1'b1 || busy !== 1'b1) $display("FAIL basic_update_c10: got upd=%b busy=%b want 1/1", update, busy); else n_pass++;
    for (int i = 0; i < WPL; i++) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL basic_sb_empty: got empty queue want word %0d", i);
      else begin
        e = exp_q.pop_front();
        if (words[i] !== e) $display("FAIL basic_word%0d: got %h want %h", i, words[i], e); else n_pass++;
      end
    end
    n_checks++;
    if (fill_addr !== 32'h0000_1220) $display("FAIL basic_fill_addr: got %h want 00001220", fill_addr); else n_pass++;
    tick();                                   // c11
    n_checks++;
    if (update !== 1'b0 || busy !== 1'b0) $display("FAIL basic_c11: got upd=%b busy=%b want 0/0", update, busy); else n_pass++;
  endtask

  task automatic test_stalls();
    int req_cyc;
    int upd0;
    logic [31:0] e;
    req_cyc = 0;
    upd0 = upd_seen;
    miss_req = 1'b1; miss_addr = 32'h0000_5678;
    tick();
    miss_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (mem_req === 1'b1) req_cyc++;
      mem_gnt = (c == 3) ? 1'b1 : 1'b0;
      tick();
    end
    mem_gnt = 1'b0;
    n_checks++;
    if (req_cyc != 4 || mem_req !== 1'b0) $display("FAIL stall_req_hold: got %0d cycles (req now %b) want 4 (0)", req_cyc, mem_req); else n_pass++;
    n_checks++;
    if (mem_addr !== 32'h0000_5660) $display("FAIL stall_mem_addr: got %h want 00005660", mem_addr); else n_pass++;
    for (int i = 0; i < WPL; i++) begin
      send_beat(32'h5000 + 32'(i), i, 1'b1, 1'b1);
      if (i == 2 || i == 5) begin tick(); tick(); end
    end
    n_checks++;
    if (update !== 1'b1) $display("FAIL stall_update: got %b want 1", update); else n_pass++;
    for (int i = 0; i < WPL; i++) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL stall_sb_empty: got empty queue want word %0d", i);
      else begin
        e = exp_q.pop_front();
        if (words[i] !== e) $display("FAIL stall_word%0d: got %h want %h", i, words[i], e); else n_pass++;
      end
    end
    tick(); tick(); tick();
    n_checks++;
    if (upd_seen - upd0 != 1) $display("FAIL stall_update_once: got %0d pulses want 1", upd_seen - upd0); else n_pass++;
  endtask

  task automatic test_flush_recv();
    int upd0;
    upd0 = upd_seen;
    miss_req = 1'b1; miss_addr = 32'h0000_9ABC;
    tick();
    miss_req = 1'b0;
    n_checks++;
    if (mem_addr !== 32'h0000_9AA0) $display("FAIL frecv_mem_addr: got %h want 00009aa0", mem_addr); else n_pass++;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) send_beat(32'hC0 + 32'(i), i, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL frecv_drain_busy: got %b want 1", busy); else n_pass++;
    for (int i = 4; i < WPL; i++) send_beat(32'hDEAD_0000 + 32'(i), i, 1'b0, 1'b0);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL frecv_idle: got busy=%b want 0", busy); else n_pass++;
    for (int i = 0; i < WPL; i++) begin
      n_checks++;
      if (words[i] !== model_words[i]) $display("FAIL frecv_word%0d: got %h want %h", i, words[i], model_words[i]); else n_pass++;
    end
    tick();
    n_checks++;
    if (upd_seen != upd0) $display("FAIL frecv_no_update: got %0d pulses want 0", upd_seen - upd0); else n_pass++;
  endtask

  task automatic test_flush_req();
    int upd0;
    int busy_cyc;
    upd0 = upd_seen;
    busy_cyc = 0;
    miss_req = 1'b1; miss_addr = 32'h0000_2000;
    tick();
    miss_req = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1) $display("FAIL freq_req: got %b want 1", mem_req); else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL freq_abort: got req=%b busy=%b want 0/0", mem_req, busy); else n_pass++;
    for (int c = 0; c < 3; c++) begin
      if (busy !== 1'b0 || mem_req !== 1'b0) busy_cyc++;
      tick();
    end
    n_checks++;
    if (busy_cyc != 0) $display("FAIL freq_stay_idle: got %0d busy cycles want 0", busy_cyc); else n_pass++;
    miss_req = 1'b1; miss_addr = 32'h0000_3000;
    tick();
    miss_req = 1'b0;
    mem_gnt = 1'b1; flush = 1'b1;
    tick();
    mem_gnt = 1'b0; flush = 1'b0;
    n_checks++;
    if (mem_req !== 1'b0 || busy !== 1'b1) $display("FAIL freq_gnt_drain: got req=%b busy=%b want 0/1", mem_req, busy); else n_pass++;
    for (int i = 0; i < WPL; i++) begin
      n_checks++;
      if (busy !== 1'b1) $display("FAIL freq_drain_beat%0d: got busy=%b want 1", i, busy); else n_pass++;
      send_beat(32'hFEED_0000 + 32'(i), i, 1'b0, 1'b0);
    end
    n_checks++;
    if (busy !== 1'b0) $display("FAIL freq_drain_done: got busy=%b want 0", busy); else n_pass++;
    n_checks++;
    if (words[0] !== model_words[0] || words[7] !== model_words[7]) $display("FAIL freq_words_kept: got %h/%h want %h/%h", words[0], words[7], model_words[0], model_words[7]); else n_pass++;
    n_checks++;
    if (upd_seen != upd0) $display("FAIL freq_no_update: got %0d pulses want 0", upd_seen - upd0); else n_pass++;
  endtask

  task automatic test_async_reset();
    int upd0;
    int busy_cyc;
    busy_cyc = 0;
    miss_req = 1'b1; miss_addr = 32'h0000_4444;
    tick();
    miss_req = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(32'h4400 + 32'(i), i, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < WPL; i++) model_words[i] = 32'h0;
    n_checks++;
    if ({mem_req, update, busy} !== 3'b000) $display("FAIL areset_ctrl: got req/upd/busy=%b want 000", {mem_req, update, busy}); else n_pass++;
    n_checks++;
    if (words !== '0 || fill_addr !== 32'h0) $display("FAIL areset_data: got words=%h fill=%h want 0", words, fill_addr); else n_pass++;
    tick(); tick();
    rst_n = 1'b1;
    upd0 = upd_seen;
    for (int c = 0; c < 12; c++) begin
      mem_rvalid = c[0];
      mem_rdata  = 32'hBAD0_0000 + 32'(c);
      if (busy !== 1'b0) busy_cyc++;
      tick();
    end
    mem_rvalid = 1'b0;
    n_checks++;
    if (upd_seen != upd0 || busy_cyc != 0) $display("FAIL areset_quiet: got upd=%0d busy_cyc=%0d want 0/0", upd_seen - upd0, busy_cyc); else n_pass++;
    n_checks++;
    if (words !== '0) $display("FAIL areset_stray: got %h want 0", words); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    int addr_bad;
    addr_bad = 0;
    miss_req = 1'b1; miss_addr = 32'h0000_7000;  // c0
    tick();                                      // c1
    miss_addr = 32'h0000_7F24;
    mem_gnt = 1'b1;
    tick();                                      // c2
    mem_gnt = 1'b0;
    for (int i = 0; i < WPL; i++) begin
      if (mem_addr !== 32'h0000_7000) addr_bad++;
      send_beat(32'h70 + 32'(i), i, 1'b1, 1'b1);
    end
    n_checks++;                                  // c10
    if (update !== 1'b1 || fill_addr !== 32'h0000_7000 || addr_bad != 0) $display("FAIL b2b_first: got upd=%b fill=%h addr_bad=%0d want 1/00007000/0", update, fill_addr, addr_bad); else n_pass++;
    for (int i = 0; i < WPL; i++) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL b2b_sb_empty: got empty queue want word %0d", i);
      else begin
        e = exp_q.pop_front();
        if (words[i] !== e) $display("FAIL b2b_word%0d: got %h want %h", i, words[i], e); else n_pass++;
      end
    end
    tick();                                      // c11: IDLE, miss still high
    mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    n_checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) $display("FAIL b2b_idle_gap: got busy=%b req=%b want 0/0", busy, mem_req); else n_pass++;
    tick();                                      // c12
    mem_rvalid = 1'b0; miss_req = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0000_7F20) $display("FAIL b2b_second_req: got req=%b addr=%h want 1/00007f20", mem_req, mem_addr); else n_pass++;
    n_checks++;
    if (words[0] !== model_words[0]) $display("FAIL b2b_stray: got %h want %h", words[0], model_words[0]); else n_pass++;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < WPL; i++) send_beat(32'hE0 + 32'(i), i, 1'b1, 1'b1);
    n_checks++;
    if (update !== 1'b1 || fill_addr !== 32'h0000_7F20) $display("FAIL b2b_second_upd: got upd=%b fill=%h want 1/00007f20", update, fill_addr); else n_pass++;
    for (int i = 0; i < WPL; i++) begin
      n_checks++;
      if (exp_q.size() == 0) $display("FAIL b2b2_sb_empty: got empty queue want word %0d", i);
      else begin
        e = exp_q.pop_front();
        if (words[i] !== e) $display("FAIL b2b2_word%0d: got %h want %h", i, words[i], e); else n_pass++;
      end
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_flush_recv();
    test_flush_req();
    test_async_reset();
    test_back_to_back();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
